// File: rtl/kf_frame_sched.sv
// kf_frame_sched: measurement FIFO, launch/feedback FSM, result slot and
// frame watchdog sitting in front of top_kf.
`ifndef FXP_N
`define FXP_N 16
`endif
`ifndef FXP_FRAC
`define FXP_FRAC 8
`endif

module kf_frame_sched #(
    parameter int N       = `FXP_N,
    parameter int FRAC    = `FXP_FRAC,
    parameter int DEPTH   = 4,
    parameter int AW      = 2,
    parameter int TIMEOUT = 48
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_z00,
    input  logic [N-1:0] in_z10,
    input  logic         init_load,
    input  logic [N-1:0] init_x00,
    input  logic [N-1:0] init_x10,
    output logic         kf_start,
    output logic [N-1:0] kf_z00,
    output logic [N-1:0] kf_z10,
    output logic [N-1:0] kf_x00_prev,
    output logic [N-1:0] kf_x10_prev,
    input  logic         kf_done,
    input  logic [N-1:0] kf_x00_post,
    input  logic [N-1:0] kf_x10_post,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_x00,
    output logic [N-1:0] out_x10,
    output logic [7:0]   out_seq,
    output logic         busy,
    output logic         timeout_err,
    input  logic         err_clr
);
    localparam int WW = $clog2(TIMEOUT);

    if (FRAC < 0 || FRAC >= N || DEPTH != (1 << AW) || TIMEOUT < 36) begin : g_param_chk
        $error("kf_frame_sched: bad parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_GAP} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  mem_z00_q [DEPTH];
    logic [N-1:0]  mem_z10_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          gap_q, gap_d;
    logic [N-1:0]  z00_q, z10_q, xp00_q, xp10_q, ox00_q, ox10_q;
    logic [7:0]    seq_q, oseq_q;
    logic          ovalid_q, ovalid_d;
    logic          terr_q, terr_d;

    logic full, push, pop, launch, capture, expire;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign push    = in_valid && !full;
    assign launch  = (state_q == S_IDLE) && (cnt_q != '0) &&
                     (!ovalid_q || out_ready) && !init_load;
    assign pop     = launch;
    assign capture = (state_q == S_RUN) && kf_done;
    assign expire  = (state_q == S_RUN) && !kf_done &&
                     (wdog_q == WW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next state; GAP lasts two cycles so top_kf can drop running.
    always_comb begin
        state_d = state_q;
        gap_d   = (state_q == S_GAP) && !gap_q;
        wdog_d  = (state_q == S_RUN) ? wdog_q + WW'(1) : '0;
        unique case (state_q)
            S_IDLE:   if (launch) state_d = S_LAUNCH;
            S_LAUNCH: state_d = S_RUN;
            S_RUN:    if (capture || expire) state_d = S_GAP;
            S_GAP:    if (gap_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        kf_start = (state_q == S_LAUNCH);
        busy     = (state_q != S_IDLE);
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        ovalid_d = ovalid_q;
        if (capture)
            ovalid_d = 1'b1;
        else if (ovalid_q && out_ready)
            ovalid_d = 1'b0;
        terr_d = terr_q;
        if (expire)
            terr_d = 1'b1;
        else if (err_clr)
            terr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z00_q[wr_ptr_q] <= in_z00;
            mem_z10_q[wr_ptr_q] <= in_z10;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            z00_q    <= '0;
            z10_q    <= '0;
            xp00_q   <= '0;
            xp10_q   <= '0;
            ox00_q   <= '0;
            ox10_q   <= '0;
            seq_q    <= '0;
            oseq_q   <= '0;
            ovalid_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            terr_q   <= terr_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                z00_q    <= mem_z00_q[rd_ptr_q];
                z10_q    <= mem_z10_q[rd_ptr_q];
            end
            // init_load only acts in IDLE, so it never races a capture.
            if (state_q == S_IDLE && init_load) begin
                xp00_q <= init_x00;
                xp10_q <= init_x10;
            end else if (capture) begin
                xp00_q <= kf_x00_post;
                xp10_q <= kf_x10_post;
            end
            if (capture) begin
                ox00_q <= kf_x00_post;
                ox10_q <= kf_x10_post;
                oseq_q <= seq_q;
                seq_q  <= seq_q + 8'd1;
            end
        end
    end

    assign in_ready    = !full;
    assign kf_z00      = z00_q;
    assign kf_z10      = z10_q;
    assign kf_x00_prev = xp00_q;
    assign kf_x10_prev = xp10_q;
    assign out_valid   = ovalid_q;
    assign out_x00     = ox00_q;
    assign out_x10     = ox10_q;
    assign out_seq     = oseq_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_kf_frame_sched.sv
// Directed bench for kf_frame_sched with a fixed-latency top_kf stub
// whose posterior is x_prev + z per component.
module tb_kf_frame_sched;
    localparam int N       = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 48;
    localparam int LAT     = 34;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [N-1:0] in_z00 = '0, in_z10 = '0;
    logic         init_load = 1'b0;
    logic [N-1:0] init_x00 = '0, init_x10 = '0;
    logic         kf_start;
    logic [N-1:0] kf_z00, kf_z10, kf_x00_prev, kf_x10_prev;
    logic         kf_done;
    logic [N-1:0] kf_x00_post, kf_x10_post;
    logic         out_valid, out_ready = 1'b1;
    logic [N-1:0] out_x00, out_x10;
    logic [7:0]   out_seq;
    logic         busy, timeout_err, err_clr = 1'b0;

    kf_frame_sched #(.N(N), .FRAC(8), .DEPTH(DEPTH), .AW(2), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_z00(in_z00), .in_z10(in_z10),
        .init_load(init_load), .init_x00(init_x00), .init_x10(init_x10),
        .kf_start(kf_start), .kf_z00(kf_z00), .kf_z10(kf_z10),
        .kf_x00_prev(kf_x00_prev), .kf_x10_prev(kf_x10_prev),
        .kf_done(kf_done), .kf_x00_post(kf_x00_post), .kf_x10_post(kf_x10_post),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x00(out_x00), .out_x10(out_x10), .out_seq(out_seq),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // top_kf stub: done pulses LAT cycles after the start cycle.
    logic         stub_en = 1'b1;
    logic         stub_run;
    int           stub_cnt;
    logic [N-1:0] sz00, sz10, sp00, sp10;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_run <= 1'b0;
            stub_cnt <= 0;
            kf_done  <= 1'b0;
            sz00 <= '0; sz10 <= '0; sp00 <= '0; sp10 <= '0;
        end else begin
            kf_done <= 1'b0;
            if (kf_start && !stub_run) begin
                stub_run <= 1'b1;
                stub_cnt <= 1;
                sz00 <= kf_z00; sz10 <= kf_z10;
                sp00 <= kf_x00_prev; sp10 <= kf_x10_prev;
            end else if (stub_run) begin
                stub_cnt <= stub_cnt + 1;
                if (stub_cnt == LAT - 1) kf_done <= stub_en;
                if (stub_cnt == LAT) stub_run <= 1'b0;
            end
        end
    end

    assign kf_x00_post = sp00 + sz00;
    assign kf_x10_post = sp10 + sz10;

    // Monitors
    int           q_start [$];
    logic [N-1:0] q_z00 [$], q_z10 [$], q_p00 [$], q_p10 [$];
    logic [N-1:0] q_o00 [$], q_o10 [$];
    logic [7:0]   q_seq [$];
    int           done_cyc = 0, ov_cyc = 0;
    logic         ov_prev = 1'b0;

    always @(negedge clk) begin
        ov_prev <= out_valid;
        if (rst_n && kf_start) begin
            q_start.push_back(cyc);
            q_z00.push_back(kf_z00); q_z10.push_back(kf_z10);
            q_p00.push_back(kf_x00_prev); q_p10.push_back(kf_x10_prev);
        end
        if (rst_n && kf_done) begin
            done_cyc <= cyc;
            chk("hold_z00", kf_z00, sz00);
            chk("hold_x10_prev", kf_x10_prev, sp10);
        end
        if (rst_n && out_valid && !ov_prev) ov_cyc <= cyc;
        if (rst_n && out_valid && out_ready) begin
            q_o00.push_back(out_x00); q_o10.push_back(out_x10);
            q_seq.push_back(out_seq);
        end
    end

    typedef struct {
        logic [N-1:0] z00, z10, p00, p10, o00, o10;
        logic [7:0]   seq;
    } vec_t;
    vec_t tbl [5];

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b0; init_load = 1'b0;
        err_clr = 1'b0; out_ready = 1'b1; stub_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push1(input logic [N-1:0] a, input logic [N-1:0] b);
        in_valid = 1'b1; in_z00 = a; in_z10 = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_outs(input int n, input int budget, input string nm);
        int k = 0;
        while (q_o00.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, q_o00.size(), n);
    endtask

    task automatic wait_start(input int budget, input string nm);
        int k = 0;
        while (!kf_start && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(nm, kf_start, 1'b1);
    endtask

    initial begin
        int base, k, c0;
        tbl[0] = '{16'h0011, 16'h0022, 16'h0100, 16'h0200, 16'h0111, 16'h0222, 8'd0};
        tbl[1] = '{16'h0001, 16'h0010, 16'h0100, 16'h0200, 16'h0101, 16'h0210, 8'd0};
        tbl[2] = '{16'h0002, 16'h0020, 16'h0101, 16'h0210, 16'h0103, 16'h0230, 8'd1};
        tbl[3] = '{16'h0004, 16'h0040, 16'h0103, 16'h0230, 16'h0107, 16'h0270, 8'd2};
        tbl[4] = '{16'h0008, 16'h0080, 16'h0107, 16'h0270, 16'h010F, 16'h02F0, 8'd3};

        // 1: reset state and a single frame
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_start", kf_start, 1'b0);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_seq", out_seq, 8'd0);
        chk("rst_terr", timeout_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_xprev", kf_x00_prev, 16'h0);
        init_x00 = 16'h0100; init_x10 = 16'h0200; init_load = 1'b1;
        @(negedge clk);
        init_load = 1'b0;
        push1(tbl[0].z00, tbl[0].z10);
        wait_outs(1, 150, "t1_out");
        repeat (10) @(negedge clk);
        chk("t1_starts", q_start.size(), 1);
        chk("t1_ov_lat", ov_cyc - done_cyc, 1);

        // 2: four queued frames with feedback
        do_reset();
        init_load = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_z00 = tbl[i].z00; in_z10 = tbl[i].z10;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t2_full", in_ready, 1'b0);
        init_load = 1'b0;
        wait_outs(5, 400, "t2_out");
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("v%0d_z00", i), q_z00[i], tbl[i].z00);
            chk($sformatf("v%0d_z10", i), q_z10[i], tbl[i].z10);
            chk($sformatf("v%0d_p00", i), q_p00[i], tbl[i].p00);
            chk($sformatf("v%0d_p10", i), q_p10[i], tbl[i].p10);
            chk($sformatf("v%0d_o00", i), q_o00[i], tbl[i].o00);
            chk($sformatf("v%0d_o10", i), q_o10[i], tbl[i].o10);
            chk($sformatf("v%0d_seq", i), q_seq[i], tbl[i].seq);
        end
        for (int i = 2; i <= 4; i++)
            chk($sformatf("t2_spacing%0d", i), (q_start[i] - q_start[i-1]) >= 38, 1'b1);

        // 3: output back-pressure holds further launches
        do_reset();
        out_ready = 1'b0;
        base = q_start.size();
        in_valid = 1'b1; in_z00 = 16'h0005; in_z10 = 16'h0006;
        @(negedge clk);
        in_z00 = 16'h0007; in_z10 = 16'h0008;
        @(negedge clk);
        in_z00 = 16'h0009; in_z10 = 16'h000A;
        @(negedge clk);
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        repeat (60) @(negedge clk);
        chk("t3_one_start", q_start.size() - base, 1);
        chk("t3_ovalid", out_valid, 1'b1);
        chk("t3_ox00", out_x00, 16'h0005);
        chk("t3_ox10", out_x10, 16'h0006);
        chk("t3_oseq", out_seq, 8'd0);
        out_ready = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!kf_start && k < 5);
        chk("t3_relaunch", (kf_start && k <= 2), 1'b1);
        chk("t3_z_next", kf_z00, 16'h0007);

        // 4: watchdog
        do_reset();
        stub_en = 1'b0;
        push1(16'h0033, 16'h0044);
        wait_start(20, "t4_launch");
        c0 = cyc + 1;
        k = 0;
        while (!timeout_err && k < 100) begin @(negedge clk); k++; end
        chk("t4_to_lat", cyc - c0, TIMEOUT);
        chk("t4_gap1", busy, 1'b1);
        @(negedge clk);
        chk("t4_gap2", busy, 1'b1);
        @(negedge clk);
        chk("t4_idle", busy, 1'b0);
        chk("t4_ovalid", out_valid, 1'b0);
        chk("t4_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_clr", timeout_err, 1'b0);
        stub_en = 1'b1;
        push1(16'h0055, 16'h0066);
        k = 0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        chk("t4_seq_kept", out_seq, 8'd0);
        chk("t4_xprev_kept", out_x00, 16'h0055);

        // 5: reset in the middle of RUN with a backlog
        do_reset();
        init_load = 1'b1;
        for (int i = 0; i < 4; i++) push1(16'h0A00 + 16'(i), 16'h0A10);
        init_load = 1'b0;
        wait_start(10, "t5_launch");
        repeat (10) @(negedge clk);
        chk("t5_running", busy, 1'b1);
        base = q_start.size();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1'b0);
        chk("t5_z00", kf_z00, 16'h0);
        chk("t5_ovalid", out_valid, 1'b0);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("t5_no_start", q_start.size(), base);
        chk("t5_in_ready", in_ready, 1'b1);
        push1(16'h0C0C, 16'h0D0D);
        wait_start(10, "t5_new_start");
        chk("t5_new_head", kf_z00, 16'h0C0C);

        // 6: push against a full FIFO on the pop cycle
        do_reset();
        init_load = 1'b1;
        for (int i = 1; i <= 4; i++) push1(16'h0B00 + 16'(i), 16'h0B10);
        chk("t6_full", in_ready, 1'b0);
        base = q_start.size();
        init_load = 1'b0;
        in_valid = 1'b1; in_z00 = 16'h0EEE; in_z10 = 16'h0EEE;
        @(negedge clk);
        in_valid = 1'b0;
        chk("t6_popped", kf_start, 1'b1);
        chk("t6_cnt3", in_ready, 1'b1);
        repeat (220) @(negedge clk);
        chk("t6_frames", q_start.size() - base, 4);
        chk("t6_last", q_z00[q_start.size() - 1], 16'h0B04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end
endmodule
